// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer_if
//  Description : Dispatch / completion / retire bundle for reorder_buffer.
//                The master side drives dispatch and completion requests and
//                observes retirement; the slave side is the reorder buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if;
    // Dispatch, two slots per cycle
    logic        disp_valid_a;
    logic        disp_valid_b;
    logic [31:0] disp_pc_a;
    logic [31:0] disp_pc_b;
    logic [5:0]  disp_rd_a;
    logic [5:0]  disp_rd_b;
    logic [5:0]  disp_rd_old_a;
    logic [5:0]  disp_rd_old_b;
    logic        disp_ready;
    logic [3:0]  disp_rob_num_a;
    logic [3:0]  disp_rob_num_b;
    // Completion, one port per functional unit (alu1, alu2, mem)
    logic [2:0]  cmpl_valid;
    logic [3:0]  cmpl_rob_num0;
    logic [3:0]  cmpl_rob_num1;
    logic [3:0]  cmpl_rob_num2;
    logic [31:0] cmpl_result0;
    logic [31:0] cmpl_result1;
    logic [31:0] cmpl_result2;
    // Retirement, two slots per cycle
    logic        retire_valid_a;
    logic        retire_valid_b;
    logic [31:0] retire_pc_a;
    logic [31:0] retire_pc_b;
    logic [5:0]  retire_rd_a;
    logic [5:0]  retire_rd_b;
    logic [5:0]  retire_rd_old_a;
    logic [5:0]  retire_rd_old_b;
    logic [31:0] retire_result_a;
    logic [31:0] retire_result_b;
    logic [4:0]  rob_count;

    modport master (
        output disp_valid_a, disp_valid_b, disp_pc_a, disp_pc_b,
               disp_rd_a, disp_rd_b, disp_rd_old_a, disp_rd_old_b,
               cmpl_valid, cmpl_rob_num0, cmpl_rob_num1, cmpl_rob_num2,
               cmpl_result0, cmpl_result1, cmpl_result2,
        input  disp_ready, disp_rob_num_a, disp_rob_num_b,
               retire_valid_a, retire_valid_b, retire_pc_a, retire_pc_b,
               retire_rd_a, retire_rd_b, retire_rd_old_a, retire_rd_old_b,
               retire_result_a, retire_result_b, rob_count
    );

    modport slave (
        input  disp_valid_a, disp_valid_b, disp_pc_a, disp_pc_b,
               disp_rd_a, disp_rd_b, disp_rd_old_a, disp_rd_old_b,
               cmpl_valid, cmpl_rob_num0, cmpl_rob_num1, cmpl_rob_num2,
               cmpl_result0, cmpl_result1, cmpl_result2,
        output disp_ready, disp_rob_num_a, disp_rob_num_b,
               retire_valid_a, retire_valid_b, retire_pc_a, retire_pc_b,
               retire_rd_a, retire_rd_b, retire_rd_old_a, retire_rd_old_b,
               retire_result_a, retire_result_b, rob_count
    );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : 16-entry in-order retirement buffer. Dual dispatch, three
//                completion ports (lower port index wins on a collision),
//                in-order retirement of completed entries with no
//                back-pressure. Define ROB_DUAL_RETIRE_EN to retire two
//                entries per cycle; otherwise at most one retires per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_DEPTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    reorder_buffer_if.slave rob
);
    localparam int              c_PTR_W   = 4;
    localparam int              c_CNT_W   = 5;
    localparam int              c_NCMPL   = 3;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(ROB_DEPTH);

    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    logic [31:0]          r_pc     [ROB_DEPTH];
    logic [5:0]           r_rd     [ROB_DEPTH];
    logic [5:0]           r_rd_old [ROB_DEPTH];
    logic [31:0]          r_result [ROB_DEPTH];

    logic [c_PTR_W-1:0]   w_tail_p1;
    logic                 w_disp_ready;
    logic                 w_alloc_a;
    logic                 w_alloc_b;
    logic                 w_ret_a;
    logic                 w_ret_b;
    logic [1:0]           w_n_alloc;
    logic [1:0]           w_n_ret;
    logic [c_PTR_W-1:0]   w_cmpl_num [c_NCMPL];
    logic [31:0]          w_cmpl_res [c_NCMPL];
    logic [c_NCMPL-1:0]   w_cmpl_hit;

    // Ready only looks at registered occupancy; same-cycle retires are not credited
    assign w_disp_ready = (c_DEPTH - r_count) >= c_CNT_W'(2);
    assign w_tail_p1    = r_tail + c_PTR_W'(1);
    assign w_alloc_a    = w_disp_ready & rob.disp_valid_a;
    assign w_alloc_b    = w_alloc_a & rob.disp_valid_b;
    assign w_n_alloc    = {1'b0, w_alloc_a} + {1'b0, w_alloc_b};

    assign w_cmpl_num[0] = rob.cmpl_rob_num0;
    assign w_cmpl_num[1] = rob.cmpl_rob_num1;
    assign w_cmpl_num[2] = rob.cmpl_rob_num2;
    assign w_cmpl_res[0] = rob.cmpl_result0;
    assign w_cmpl_res[1] = rob.cmpl_result1;
    assign w_cmpl_res[2] = rob.cmpl_result2;

    // A completion only counts when it lands on an occupied entry
    always_comb begin
        w_cmpl_hit = '0;
        for (int p = 0; p < c_NCMPL; p++) begin
            w_cmpl_hit[p] = rob.cmpl_valid[p] & r_valid[w_cmpl_num[p]];
        end
    end

    assign w_ret_a = r_valid[r_head] & r_done[r_head];

`ifdef ROB_DUAL_RETIRE_EN
    logic [c_PTR_W-1:0] w_head_p1;
    assign w_head_p1 = r_head + c_PTR_W'(1);
    assign w_ret_b   = w_ret_a & r_valid[w_head_p1] & r_done[w_head_p1];
    assign rob.retire_pc_b     = w_ret_b ? r_pc[w_head_p1]     : '0;
    assign rob.retire_rd_b     = w_ret_b ? r_rd[w_head_p1]     : '0;
    assign rob.retire_rd_old_b = w_ret_b ? r_rd_old[w_head_p1] : '0;
    assign rob.retire_result_b = w_ret_b ? r_result[w_head_p1] : '0;
`else
    assign w_ret_b             = 1'b0;
    assign rob.retire_pc_b     = '0;
    assign rob.retire_rd_b     = '0;
    assign rob.retire_rd_old_b = '0;
    assign rob.retire_result_b = '0;
`endif

    assign w_n_ret = {1'b0, w_ret_a} + {1'b0, w_ret_b};

    assign rob.disp_ready      = w_disp_ready;
    assign rob.disp_rob_num_a  = r_tail;
    assign rob.disp_rob_num_b  = w_tail_p1;
    assign rob.retire_valid_a  = w_ret_a;
    assign rob.retire_valid_b  = w_ret_b;
    assign rob.retire_pc_a     = w_ret_a ? r_pc[r_head]     : '0;
    assign rob.retire_rd_a     = w_ret_a ? r_rd[r_head]     : '0;
    assign rob.retire_rd_old_a = w_ret_a ? r_rd_old[r_head] : '0;
    assign rob.retire_result_a = w_ret_a ? r_result[r_head] : '0;
    assign rob.rob_count       = r_count;

    // Pointers, occupancy and per-entry valid/done; retire clears win last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_n_ret);
            r_tail  <= r_tail + c_PTR_W'(w_n_alloc);
            r_count <= r_count + c_CNT_W'(w_n_alloc) - c_CNT_W'(w_n_ret);
            for (int p = 0; p < c_NCMPL; p++) begin
                if (w_cmpl_hit[p]) begin
                    r_done[w_cmpl_num[p]] <= 1'b1;
                end
            end
            if (w_alloc_a) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
            end
            if (w_alloc_b) begin
                r_valid[w_tail_p1] <= 1'b1;
                r_done[w_tail_p1]  <= 1'b0;
            end
            if (w_ret_a) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
            end
            if (w_ret_b) begin
                r_valid[r_head + c_PTR_W'(1)] <= 1'b0;
                r_done[r_head + c_PTR_W'(1)]  <= 1'b0;
            end
        end
    end

    // Entry payload; port 0 is written last so it wins a same-entry collision
    always_ff @(posedge clk) begin
        if (w_alloc_a) begin
            r_pc[r_tail]     <= rob.disp_pc_a;
            r_rd[r_tail]     <= rob.disp_rd_a;
            r_rd_old[r_tail] <= rob.disp_rd_old_a;
        end
        if (w_alloc_b) begin
            r_pc[w_tail_p1]     <= rob.disp_pc_b;
            r_rd[w_tail_p1]     <= rob.disp_rd_b;
            r_rd_old[w_tail_p1] <= rob.disp_rd_old_b;
        end
        for (int p = c_NCMPL - 1; p >= 0; p--) begin
            if (w_cmpl_hit[p]) begin
                r_result[w_cmpl_num[p]] <= w_cmpl_res[p];
            end
        end
    end
endmodule
`default_nettype wire
